// File: rtl/param_stack_if.sv
// Handshake and status bundle for param_stack: the datapath master drives
// push/pop/din/err_clr, the stack (slave) returns top-of-stack and status.
interface param_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, din, err_clr,
    input  dout, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, din, err_clr,
    output dout, count, empty, full, ovf, unf
  );
endinterface

// File: rtl/param_stack.sv
// Parametrised register-file LIFO with replace-top, registered status and
// overflow/underflow flags; STACK_ERR_STICKY_EN makes the flags sticky until err_clr.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst_n,
  param_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    sp_r;
  logic [WIDTH-1:0] dout_r;
  logic             empty_r;
  logic             full_r;
  logic             ovf_r;
  logic             unf_r;

  logic [CW-1:0]    sp_nxt_s;
  logic [WIDTH-1:0] dout_nxt_s;
  logic             we_s;
  logic [AW-1:0]    wa_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic [AW-1:0]    top_idx_s;
  logic [AW-1:0]    push_idx_s;
  logic [AW-1:0]    below_idx_s;

  assign top_idx_s   = AW'(sp_r - CW'(1));
  assign push_idx_s  = AW'(sp_r);
  assign below_idx_s = AW'(sp_r - CW'(2));

  // Operation decode: next pointer, next top-of-stack, storage write and error events
  always_comb begin
    sp_nxt_s   = sp_r;
    dout_nxt_s = dout_r;
    we_s       = 1'b0;
    wa_s       = top_idx_s;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    if (bus.push && bus.pop && !empty_r) begin
      we_s       = 1'b1;
      wa_s       = top_idx_s;
      dout_nxt_s = bus.din;
    end else if (bus.push && !full_r) begin
      // Also covers push+pop on an empty stack, which behaves as a plain push
      we_s       = 1'b1;
      wa_s       = push_idx_s;
      sp_nxt_s   = sp_r + CW'(1);
      dout_nxt_s = bus.din;
    end else if (bus.push && !bus.pop) begin
      ovf_set_s = 1'b1;
    end else if (bus.pop && !bus.push && !empty_r) begin
      sp_nxt_s   = sp_r - CW'(1);
      dout_nxt_s = (sp_r > CW'(1)) ? mem_r[below_idx_s] : {WIDTH{1'b0}};
    end else if (bus.pop && !bus.push) begin
      unf_set_s = 1'b1;
    end else begin
      sp_nxt_s = sp_r;
    end
  end

  // Storage write; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wa_s] <= bus.din;
    end
  end

  // Pointer, top-of-stack and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r    <= {CW{1'b0}};
      dout_r  <= {WIDTH{1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      sp_r    <= sp_nxt_s;
      dout_r  <= dout_nxt_s;
      empty_r <= (sp_nxt_s == {CW{1'b0}});
      full_r  <= (sp_nxt_s == CW'(DEPTH));
    end
  end

`ifdef STACK_ERR_STICKY_EN
  // Sticky error flags: a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_set_s | (ovf_r & ~bus.err_clr);
      unf_r <= unf_set_s | (unf_r & ~bus.err_clr);
    end
  end
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = bus.err_clr;

  // Single-cycle error pulses, one cycle after the offending edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_set_s;
      unf_r <= unf_set_s;
    end
  end
`endif

  assign bus.dout  = dout_r;
  assign bus.count = sp_r;
  assign bus.empty = empty_r;
  assign bus.full  = full_r;
  assign bus.ovf   = ovf_r;
  assign bus.unf   = unf_r;
endmodule

// File: tb/tb_param_stack.sv
// Directed scoreboard bench for param_stack (WIDTH=8, DEPTH=4); expected
// flag persistence follows STACK_ERR_STICKY_EN when the bench is built with it.
module tb_param_stack;
  typedef struct {
    logic [7:0] dout;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

`ifdef STACK_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  param_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();

  param_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] d, input logic [2:0] c,
                              input logic e, input logic f,
                              input logic o, input logic u);
    exp_t r;
    r.dout  = d;
    r.count = c;
    r.empty = e;
    r.full  = f;
    r.ovf   = o;
    r.unf   = u;
    return r;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s scoreboard empty got 0 entries required 1", tag);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    assert (bus.dout === e.dout) else begin
      n_err++;
      $error("FAIL %s dout got %h required %h", tag, bus.dout, e.dout);
    end
    n_vec++;
    assert (bus.count === e.count) else begin
      n_err++;
      $error("FAIL %s count got %0d required %0d", tag, bus.count, e.count);
    end
    n_vec++;
    assert (bus.empty === e.empty) else begin
      n_err++;
      $error("FAIL %s empty got %b required %b", tag, bus.empty, e.empty);
    end
    n_vec++;
    assert (bus.full === e.full) else begin
      n_err++;
      $error("FAIL %s full got %b required %b", tag, bus.full, e.full);
    end
    n_vec++;
    assert (bus.ovf === e.ovf) else begin
      n_err++;
      $error("FAIL %s ovf got %b required %b", tag, bus.ovf, e.ovf);
    end
    n_vec++;
    assert (bus.unf === e.unf) else begin
      n_err++;
      $error("FAIL %s unf got %b required %b", tag, bus.unf, e.unf);
    end
  endtask

  // Drive one cycle of stimulus, record the expected result, compare after the edge
  task automatic step(input logic p, input logic q, input logic [7:0] d,
                      input logic clr, input exp_t e, input string tag);
    bus.push    = p;
    bus.pop     = q;
    bus.din     = d;
    bus.err_clr = clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.din     = 8'h00;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    check("reset");
    rst_n = 1'b1;

    step(1'b1, 1'b0, 8'h11, 1'b0, mk(8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0), "push1");
    step(1'b1, 1'b0, 8'h22, 1'b0, mk(8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0), "push2");
    step(1'b1, 1'b0, 8'h33, 1'b0, mk(8'h33, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0), "push3");
    step(1'b1, 1'b0, 8'h44, 1'b0, mk(8'h44, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0), "push4");
    step(1'b1, 1'b0, 8'h55, 1'b0, mk(8'h44, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0), "ovf");
    step(1'b0, 1'b0, 8'h00, 1'b0, mk(8'h44, 3'd4, 1'b0, 1'b1, STICKY, 1'b0), "ovf_after");
    step(1'b1, 1'b1, 8'hAA, 1'b0, mk(8'hAA, 3'd4, 1'b0, 1'b1, STICKY, 1'b0), "replace_full");
    step(1'b0, 1'b0, 8'h00, 1'b1, mk(8'hAA, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0), "ovf_clr");
    step(1'b0, 1'b1, 8'h00, 1'b0, mk(8'h33, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0), "pop1");
    step(1'b0, 1'b1, 8'h00, 1'b0, mk(8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0), "pop2");
    step(1'b0, 1'b1, 8'h00, 1'b0, mk(8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0), "pop3");
    step(1'b0, 1'b1, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0), "pop4");
    step(1'b0, 1'b1, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1), "unf");
    step(1'b0, 1'b0, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, STICKY), "unf_after");
    step(1'b0, 1'b0, 8'h00, 1'b1, mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0), "unf_clr");
    step(1'b1, 1'b1, 8'h5A, 1'b0, mk(8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0), "pushpop_empty");
    step(1'b0, 1'b1, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0), "pop5");
    step(1'b0, 1'b1, 8'h00, 1'b1, mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1), "unf_with_clr");
    step(1'b0, 1'b0, 8'h00, 1'b1, mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0), "unf_clr2");
    step(1'b1, 1'b0, 8'h77, 1'b0, mk(8'h77, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0), "push77");

    // Asynchronous reset between edges, then a request held while in reset
    bus.push = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    check("async_rst");
    bus.push = 1'b1;
    bus.din  = 8'h99;
    @(posedge clk);
    #1;
    sb.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    check("rst_hold");
    bus.push = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0), "post_rst");
    step(1'b1, 1'b0, 8'h3C, 1'b0, mk(8'h3C, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0), "post_rst_push");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
